// File: rtl/control_ternario_pkg.sv
// control_ternario_pkg
// Shared definitions for the control_ternario select generator:
//   - FSM state encodings (ESTADO_IDLE, ESTADO_HOLD)
//   - source indices (FUENTE_A/B/C), matching the req/grant bit order
//   - selector encodings, ordered {s2,s1}
//   - helpers mapping a one-hot grant to its select code and source index
// No ports; imported by every other file of the block.
package control_ternario_pkg;

  typedef enum logic {
    ESTADO_IDLE = 1'b0,
    ESTADO_HOLD = 1'b1
  } estado_t;

  typedef enum logic [1:0] {
    FUENTE_A = 2'd0,
    FUENTE_B = 2'd1,
    FUENTE_C = 2'd2
  } fuente_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  function automatic logic [1:0] sel_de(input logic [2:0] g);
    case (g)
      3'b010:  return SEL_B;
      3'b100:  return SEL_C;
      default: return SEL_A;
    endcase
  endfunction

  function automatic fuente_t indice_de(input logic [2:0] g);
    case (g)
      3'b010:  return FUENTE_B;
      3'b100:  return FUENTE_C;
      default: return FUENTE_A;
    endcase
  endfunction

endpackage

// File: rtl/control_ternario_if.sv
// control_ternario_if
// Request/select bundle between the requesting sources and the
// control_ternario select generator.
//   req   [2:0] request flags (bit0=a, bit1=b, bit2=c)
//   s1          low-level select (a vs b)
//   s2          high-level select (c vs a/b)
//   grant [2:0] one-hot grant, same bit order as req
//   busy        burst active
//   done        one-cycle pulse after a burst ends
// Modports: master drives req and observes the rest; slave is the generator.
interface control_ternario_if;
  logic [2:0] req;
  logic       s1;
  logic       s2;
  logic [2:0] grant;
  logic       busy;
  logic       done;

  modport master (output req, input s1, s2, grant, busy, done);
  modport slave  (input req, output s1, s2, grant, busy, done);
endinterface

// File: rtl/control_ternario_arbitro_rr.sv
// arbitro_rr
// Combinational arbiter: maps the request vector to a one-hot winner.
// Default build: round-robin starting after the last-served source
// (a -> b -> c -> a). With PRIORIDAD_FIJA_EN defined it becomes a fixed
// priority encoder c > b > a and the last-served input disappears.
//   ultimo [1:0] last-served source (round-robin build only)
//   req    [2:0] request flags
//   gana   [2:0] one-hot winner, 0 when req == 0
module arbitro_rr
  import control_ternario_pkg::*;
(
`ifndef PRIORIDAD_FIJA_EN
  input  fuente_t    ultimo,
`endif
  input  logic [2:0] req,
  output logic [2:0] gana
);

`ifdef PRIORIDAD_FIJA_EN
  always_comb begin
    gana = 3'b000;
    if (req[2])      gana = 3'b100;
    else if (req[1]) gana = 3'b010;
    else if (req[0]) gana = 3'b001;
  end
`else
  // Search order is rotated so the last-served source is checked last.
  always_comb begin
    gana = 3'b000;
    case (ultimo)
      FUENTE_A: begin
        if (req[1])      gana = 3'b010;
        else if (req[2]) gana = 3'b100;
        else if (req[0]) gana = 3'b001;
      end
      FUENTE_B: begin
        if (req[2])      gana = 3'b100;
        else if (req[0]) gana = 3'b001;
        else if (req[1]) gana = 3'b010;
      end
      default: begin
        if (req[0])      gana = 3'b001;
        else if (req[1]) gana = 3'b010;
        else if (req[2]) gana = 3'b100;
      end
    endcase
  end
`endif

endmodule

// File: rtl/control_ternario.sv
// control_ternario
// Select generator upstream of the two-level 3:1 selector. Arbitrates
// among sources a/b/c, holds each grant for RAFAGA cycles (or less if the
// granted request drops) and drives registered s1/s2 selects.
//   clk      rising-edge clock
//   reset_L  asynchronous active-low reset
//   bus      control_ternario_if.slave (req in; s1, s2, grant, busy, done out)
// Parameters: RAFAGA burst length (0 behaves as 1), ANCHO_CONT counter width.
// Build option: PRIORIDAD_FIJA_EN selects fixed priority c > b > a instead
// of round-robin; the last-served pointer is then not built.
//
// state        | meaning
// ESTADO_IDLE  | no grant, busy=0; done may be high for its one cycle
// ESTADO_HOLD  | one grant bit set, busy=1, burst counter running
module control_ternario
  import control_ternario_pkg::*;
#(
  parameter int unsigned RAFAGA     = 4,
  parameter int unsigned ANCHO_CONT = 3
) (
  input logic              clk,
  input logic              reset_L,
  control_ternario_if.slave bus
);

  localparam int unsigned           RAFAGA_EF = (RAFAGA == 0) ? 1 : RAFAGA;
  localparam logic [ANCHO_CONT-1:0] CARGA     = ANCHO_CONT'(RAFAGA_EF - 1);

  estado_t               estado_q, estado_d;
  logic [ANCHO_CONT-1:0] cont_q, cont_d;
  logic [2:0]            grant_q, grant_d;
  logic [1:0]            sel_q, sel_d;
  logic                  done_q, done_d;
  logic [2:0]            gana;
  logic                  req_vigente;

`ifndef PRIORIDAD_FIJA_EN
  fuente_t ultimo_q, ultimo_d;
`endif

  arbitro_rr u_arbitro (
`ifndef PRIORIDAD_FIJA_EN
    .ultimo (ultimo_q),
`endif
    .req    (bus.req),
    .gana   (gana)
  );

  // Only the granted source's request matters while holding.
  assign req_vigente = |(bus.req & grant_q);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado_q <= ESTADO_IDLE;
      cont_q   <= '0;
      grant_q  <= 3'b000;
      sel_q    <= SEL_A;
      done_q   <= 1'b0;
`ifndef PRIORIDAD_FIJA_EN
      ultimo_q <= FUENTE_C;
`endif
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
`ifndef PRIORIDAD_FIJA_EN
      ultimo_q <= ultimo_d;
`endif
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESTADO_IDLE: if (|bus.req) estado_d = ESTADO_HOLD;
      ESTADO_HOLD: if (cont_q == '0 || !req_vigente) estado_d = ESTADO_IDLE;
      default:     estado_d = ESTADO_IDLE;
    endcase
  end

  // Next values of the registered outputs. Selects are only rewritten on a
  // new grant, so the downstream selector never sees a spurious change.
  always_comb begin
    cont_d   = cont_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
`ifndef PRIORIDAD_FIJA_EN
    ultimo_d = ultimo_q;
`endif
    case (estado_q)
      ESTADO_IDLE: begin
        if (|bus.req) begin
          grant_d  = gana;
          cont_d   = CARGA;
          sel_d    = sel_de(gana);
`ifndef PRIORIDAD_FIJA_EN
          ultimo_d = indice_de(gana);
`endif
        end
      end
      ESTADO_HOLD: begin
        if (cont_q != '0 && req_vigente) begin
          cont_d = cont_q - 1'b1;
        end else begin
          cont_d  = '0;
          grant_d = 3'b000;
          done_d  = 1'b1;
        end
      end
      default: begin
        grant_d = 3'b000;
      end
    endcase
  end

  assign bus.s1    = sel_q[0];
  assign bus.s2    = sel_q[1];
  assign bus.grant = grant_q;
  assign bus.busy  = (estado_q == ESTADO_HOLD);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_control_ternario.sv
// tb_control_ternario
// Bench for control_ternario: two instances (RAFAGA=4 and RAFAGA=1) share
// the same directed request stimulus. A burst-level model (cycles served so
// far, last-served source) predicts every output each cycle; a few literal
// expectations pin the model to hand-worked sequences. Honors
// PRIORIDAD_FIJA_EN for the expected arbitration order.
module tb_control_ternario;

  localparam int RAF0 = 4;
  localparam int RAF1 = 1;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic chk_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_ternario_if bus0 ();
  control_ternario_if bus1 ();

  control_ternario #(.RAFAGA(RAF0), .ANCHO_CONT(3)) dut0 (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus0)
  );

  control_ternario #(.RAFAGA(RAF1), .ANCHO_CONT(3)) dut1 (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus1)
  );

  // Model state, one slot per instance.
  logic [2:0] m_grant [2] = '{3'b000, 3'b000};
  logic [1:0] m_sel   [2] = '{2'b00, 2'b00};
  logic       m_done  [2] = '{1'b0, 1'b0};
  int         m_usado [2] = '{0, 0};
  int         m_ult   [2] = '{2, 2};

  task automatic model_rst(input int d);
    m_grant[d] = 3'b000;
    m_sel[d]   = 2'b00;
    m_done[d]  = 1'b0;
    m_usado[d] = 0;
    m_ult[d]   = 2;
  endtask

  task automatic model_paso(input int d, input logic [2:0] r, input int raf);
    int gan;
    int i;
    if (m_grant[d] != 3'b000) begin
      if ((r & m_grant[d]) == 3'b000 || m_usado[d] >= raf) begin
        m_grant[d] = 3'b000;
        m_done[d]  = 1'b1;
      end else begin
        m_usado[d] = m_usado[d] + 1;
      end
    end else begin
      m_done[d] = 1'b0;
      if (r != 3'b000) begin
        gan = -1;
`ifdef PRIORIDAD_FIJA_EN
        for (int k = 0; k < 3; k++) if (r[k]) gan = k;
`else
        for (int k = 1; k <= 3; k++) begin
          i = (m_ult[d] + k) % 3;
          if (gan < 0 && r[i]) gan = i;
        end
        m_ult[d] = gan;
`endif
        m_grant[d] = 3'b001 << gan;
        m_sel[d]   = (gan == 0) ? 2'b00 : (gan == 1) ? 2'b01 : 2'b10;
        m_usado[d] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) model_rst(0);
    else          model_paso(0, bus0.req, (RAF0 < 1) ? 1 : RAF0);
  end

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) model_rst(1);
    else          model_paso(1, bus1.req, (RAF1 < 1) ? 1 : RAF1);
  end

  // Packed observation: {grant, s2, s1, busy, done}
  function automatic logic [6:0] obs(input int d);
    if (d == 0) return {bus0.grant, bus0.s2, bus0.s1, bus0.busy, bus0.done};
    return {bus1.grant, bus1.s2, bus1.s1, bus1.busy, bus1.done};
  endfunction

  function automatic logic [6:0] esperado(input int d);
    return {m_grant[d], m_sel[d], (m_grant[d] != 3'b000), m_done[d]};
  endfunction

  task automatic chk(input string nombre, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {grant,s2,s1,busy,done}=%b want %b", nombre, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ciclo_dut0", obs(0), esperado(0));
      chk("ciclo_dut1", obs(1), esperado(1));
    end
  end

  task automatic set_req(input logic [2:0] r);
    bus0.req = r;
    bus1.req = r;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_req(3'b000);
    reset_L = 1'b0;
    tick(2);
    chk_on = 1'b1;
    chk("reset_dut0", obs(0), 7'b000_00_0_0);
    chk("reset_dut1", obs(1), 7'b000_00_0_0);
    reset_L = 1'b1;

    // Single source b, 4-cycle bursts with one done cycle between.
    set_req(3'b010);
    tick(1); chk("b_inicio",  obs(0), 7'b010_01_1_0);
    tick(3); chk("b_cuarto",  obs(0), 7'b010_01_1_0);
    tick(1); chk("b_done",    obs(0), 7'b000_01_0_1);
    tick(1); chk("b_nueva",   obs(0), 7'b010_01_1_0);
    set_req(3'b000);
    tick(6);

    // All requesting; asynchronous reset mid-burst.
    set_req(3'b111);
    tick(2);
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk("rst_async_dut0", obs(0), 7'b000_00_0_0);
    chk("rst_async_dut1", obs(1), 7'b000_00_0_0);
    @(negedge clk);
    reset_L = 1'b1;

    // Arbitration order after reset.
`ifdef PRIORIDAD_FIJA_EN
    tick(1); chk("rr1", obs(0), 7'b100_10_1_0);
    tick(4); chk("rr1_done", obs(0), 7'b000_10_0_1);
    tick(1); chk("rr2", obs(0), 7'b100_10_1_0);
    tick(5); chk("rr3", obs(0), 7'b100_10_1_0);
    tick(5); chk("rr4", obs(0), 7'b100_10_1_0);
`else
    tick(1); chk("rr1", obs(0), 7'b001_00_1_0);
    tick(4); chk("rr1_done", obs(0), 7'b000_00_0_1);
    tick(1); chk("rr2", obs(0), 7'b010_01_1_0);
    tick(5); chk("rr3", obs(0), 7'b100_10_1_0);
    tick(5); chk("rr4", obs(0), 7'b001_00_1_0);
`endif
    set_req(3'b000);
    tick(6);

    // Early release of c on its second grant cycle.
    set_req(3'b100);
    tick(1); chk("c_inicio", obs(0), 7'b100_10_1_0);
    tick(1);
    set_req(3'b000);
    tick(1); chk("c_liberado", obs(0), 7'b000_10_0_1);
    tick(1); chk("c_reposo",   obs(0), 7'b000_10_0_0);

    // a and c together; RAFAGA=1 instance alternates single-cycle grants.
    set_req(3'b101);
`ifdef PRIORIDAD_FIJA_EN
    tick(1); chk("ac_primero", obs(0), 7'b100_10_1_0);
`else
    tick(1); chk("ac_primero", obs(0), 7'b001_00_1_0);
`endif
    tick(14);
    set_req(3'b000);
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
